// File: rtl/display_scan_decoder.sv
// Receiver for a multiplexed active-low 7-segment bus: recovers HH:MM:SS digits
// and converts them to binary hour/minute/second with a per-frame valid strobe.
module display_scan_decoder #(
  parameter int SETTLE = 4,
  parameter int CNT_W  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seg_out_in,
  input  logic [7:0] seg_en_in,
  output logic [5:0] hour,
  output logic [5:0] minute,
  output logic [5:0] second,
  output logic       frame_valid,
  output logic       frame_err
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HOLD} state_t;

  localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);

  state_t           state_reg, state_next;
  logic [7:0]       seg_out_s1_reg, seg_out_s2_reg;
  logic [7:0]       seg_en_s1_reg, seg_en_s2_reg;
  logic [5:0]       lat_en_reg, lat_en_next;
  logic [6:0]       lat_seg_reg, lat_seg_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [5:0]       mask_reg;
  logic [5:0]       bad_bits;
  logic [23:0]      digits;
  logic             complete_reg;
  logic             capture;
  logic             reeval;
  logic [5:0]       en;
  logic [6:0]       seg;
  logic             one_hot;
  logic             same;
  logic [4:0]       dec;
  logic             unused_bits;

  function automatic logic [4:0] decode_glyph(input logic [6:0] g);
    case (g)
      7'h3F:   return {1'b0, 4'd0};
      7'h06:   return {1'b0, 4'd1};
      7'h5B:   return {1'b0, 4'd2};
      7'h4F:   return {1'b0, 4'd3};
      7'h66:   return {1'b0, 4'd4};
      7'h6D:   return {1'b0, 4'd5};
      7'h7D:   return {1'b0, 4'd6};
      7'h27:   return {1'b0, 4'd7};
      7'h7F:   return {1'b0, 4'd8};
      7'h67:   return {1'b0, 4'd9};
      default: return {1'b1, 4'd0};
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_out_s1_reg <= 8'hFF;
      seg_out_s2_reg <= 8'hFF;
      seg_en_s1_reg  <= 8'hFF;
      seg_en_s2_reg  <= 8'hFF;
    end else begin
      seg_out_s1_reg <= seg_out_in;
      seg_out_s2_reg <= seg_out_s1_reg;
      seg_en_s1_reg  <= seg_en_in;
      seg_en_s2_reg  <= seg_en_s1_reg;
    end
  end

  // Decimal point and the two spare enables carry no information here.
  assign unused_bits = ^{seg_out_s2_reg[7], seg_en_s2_reg[7:6]};

  assign en      = ~seg_en_s2_reg[5:0];
  assign seg     = ~seg_out_s2_reg[6:0];
  assign one_hot = (en != 6'd0) && ((en & (en - 6'd1)) == 6'd0);
  assign same    = ({en, seg} == {lat_en_reg, lat_seg_reg});
  assign dec     = decode_glyph(lat_seg_reg);

  always_comb begin
    state_next   = state_reg;
    lat_en_next  = lat_en_reg;
    lat_seg_next = lat_seg_reg;
    cnt_next     = cnt_reg;
    capture      = 1'b0;
    reeval       = 1'b0;
    case (state_reg)
      S_IDLE: reeval = 1'b1;
      S_SETTLE: begin
        if (cnt_reg >= SETTLE_C) begin
          capture    = 1'b1;
          state_next = S_HOLD;
        end else if (same) begin
          cnt_next = cnt_reg + CNT_W'(1);
        end else begin
          reeval = 1'b1;
        end
      end
      S_HOLD: if (!same) reeval = 1'b1;
      default: state_next = S_IDLE;
    endcase
    // A change out of HOLD or SETTLE is judged as if freshly idle, same cycle.
    if (reeval) begin
      if (one_hot) begin
        state_next   = S_SETTLE;
        lat_en_next  = en;
        lat_seg_next = seg;
        cnt_next     = CNT_W'(1);
      end else begin
        state_next = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= S_IDLE;
      lat_en_reg  <= 6'd0;
      lat_seg_reg <= 7'd0;
      cnt_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      lat_en_reg  <= lat_en_next;
      lat_seg_reg <= lat_seg_next;
      cnt_reg     <= cnt_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_pos
      logic [3:0] digit_reg;
      logic       bad_reg;
      logic       mask_bit_reg;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          digit_reg    <= 4'd0;
          bad_reg      <= 1'b0;
          mask_bit_reg <= 1'b0;
        end else if (complete_reg) begin
          bad_reg      <= 1'b0;
          mask_bit_reg <= 1'b0;
        end else if (capture && lat_en_reg[gi]) begin
          digit_reg    <= dec[3:0];
          bad_reg      <= dec[4];
          mask_bit_reg <= 1'b1;
        end
      end
      assign digits[gi*4 +: 4] = digit_reg;
      assign bad_bits[gi]      = bad_reg;
      assign mask_reg[gi]      = mask_bit_reg;
    end
  endgenerate

  logic [6:0] hour_sum, minute_sum, second_sum;
  assign second_sum = {3'b0, digits[7:4]}   * 7'd10 + {3'b0, digits[3:0]};
  assign minute_sum = {3'b0, digits[15:12]} * 7'd10 + {3'b0, digits[11:8]};
  assign hour_sum   = {3'b0, digits[23:20]} * 7'd10 + {3'b0, digits[19:16]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      complete_reg <= 1'b0;
      hour         <= 6'd0;
      minute       <= 6'd0;
      second       <= 6'd0;
      frame_valid  <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      complete_reg <= capture && ((mask_reg | lat_en_reg) == 6'h3F);
      frame_valid  <= complete_reg;
      if (complete_reg) begin
        hour      <= hour_sum[5:0];
        minute    <= minute_sum[5:0];
        second    <= second_sum[5:0];
        frame_err <= (|bad_bits) || (hour_sum > 7'd23) ||
                     (minute_sum > 7'd59) || (second_sum > 7'd59);
      end
    end
  end

endmodule

// File: tb/tb_display_scan_decoder.sv
// Directed bench for display_scan_decoder: scans digit frames onto the bus
// and checks recovered time, error flag, pulse count and latency.
module tb_display_scan_decoder;

  logic       clk;
  logic       rst;
  logic [7:0] seg_out_in;
  logic [7:0] seg_en_in;
  logic [5:0] hour, minute, second;
  logic       frame_valid, frame_err;

  int tests = 0;
  int fails = 0;
  int pulses = 0;
  int base;
  int lat;

  display_scan_decoder #(.SETTLE(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .seg_out_in(seg_out_in), .seg_en_in(seg_en_in),
    .hour(hour), .minute(minute), .second(second),
    .frame_valid(frame_valid), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (frame_valid === 1'b1) pulses <= pulses + 1;

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h27;
      8: return 7'h7F;  default: return 7'h67;
    endcase
  endfunction

  task automatic set_bus(input int pos, input logic [6:0] g);
    logic [7:0] one;
    one = 8'h01 << pos;
    seg_en_in  = ~one;
    seg_out_in = {1'b1, ~g};
  endtask

  task automatic drive(input int pos, input logic [6:0] g, input int n);
    set_bus(pos, g);
    repeat (n) @(negedge clk);
  endtask

  task automatic blank(input int n);
    seg_en_in  = 8'hFF;
    seg_out_in = 8'hFF;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan_raw(input logic [6:0] g0, g1, g2, g3, g4, g5);
    drive(0, g0, 40); drive(1, g1, 40); drive(2, g2, 40);
    drive(3, g3, 40); drive(4, g4, 40); drive(5, g5, 40);
  endtask

  task automatic scan(input int h, input int m, input int s);
    scan_raw(glyph(s % 10), glyph(s / 10), glyph(m % 10),
             glyph(m / 10), glyph(h % 10), glyph(h / 10));
  endtask

  task automatic check_time(input string tag, input int h, input int m, input int s, input int e);
    check({tag, " hour"}, int'(hour), h);
    check({tag, " minute"}, int'(minute), m);
    check({tag, " second"}, int'(second), s);
    check({tag, " frame_err"}, int'(frame_err), e);
  endtask

  initial begin
    rst = 1'b0;
    seg_en_in = 8'hFF;
    seg_out_in = 8'hFF;
    repeat (3) @(negedge clk);
    check_time("reset", 0, 0, 0, 0);
    check("reset frame_valid", int'(frame_valid), 0);
    rst = 1'b1;
    blank(10);
    check("idle pulses", pulses, 0);

    // T1: 12:34:56 with latency from last digit to the strobe
    base = pulses;
    drive(0, glyph(6), 40); drive(1, glyph(5), 40); drive(2, glyph(4), 40);
    drive(3, glyph(3), 40); drive(4, glyph(2), 40);
    set_bus(5, glyph(1));
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (frame_valid === 1'b1 && lat == 0) lat = i;
    end
    blank(10);
    check("t1 latency", lat, 8);
    check("t1 pulses", pulses - base, 1);
    check_time("t1", 12, 34, 56, 0);

    // T2: three back-to-back scans
    base = pulses;
    scan(12, 34, 56); scan(12, 34, 56); scan(12, 34, 56);
    blank(10);
    check("t2 pulses", pulses - base, 3);
    check_time("t2", 12, 34, 56, 0);

    // T3: undecodable hour-high glyph
    base = pulses;
    scan_raw(glyph(6), glyph(5), glyph(4), glyph(3), glyph(2), 7'h41);
    blank(10);
    check("t3 pulses", pulses - base, 1);
    check_time("t3", 2, 34, 56, 1);

    // T4: decodable but out of range
    base = pulses;
    scan(27, 61, 0);
    blank(10);
    check("t4 pulses", pulses - base, 1);
    check_time("t4", 27, 61, 0, 1);

    // T5: two-cycle enable glitch onto sec-low while showing digit 3
    base = pulses;
    drive(0, glyph(6), 40); drive(1, glyph(5), 40); drive(2, glyph(4), 40);
    drive(3, glyph(3), 20); drive(0, glyph(3), 2); drive(3, glyph(3), 18);
    drive(4, glyph(2), 40); drive(5, glyph(1), 40);
    blank(10);
    check("t5 pulses", pulses - base, 1);
    check_time("t5", 12, 34, 56, 0);

    // T6: reset after four digits, then partial and full scans
    base = pulses;
    drive(0, glyph(6), 40); drive(1, glyph(5), 40);
    drive(2, glyph(4), 40); drive(3, glyph(3), 40);
    rst = 1'b0;
    seg_en_in = 8'hFF;
    seg_out_in = 8'hFF;
    repeat (3) @(negedge clk);
    check_time("t6 in reset", 0, 0, 0, 0);
    check("t6 in reset frame_valid", int'(frame_valid), 0);
    rst = 1'b1;
    blank(5);
    drive(4, glyph(0), 40); drive(5, glyph(0), 40);
    blank(10);
    check("t6 partial pulses", pulses - base, 0);
    base = pulses;
    scan(0, 0, 9);
    blank(10);
    check("t6 pulses", pulses - base, 1);
    check_time("t6", 0, 0, 9, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
